// File: rtl/demux_sched.sv
// rtl/demux_sched.sv - round-robin time-slot scheduler driving a 1-to-16 demux select (optional DEMUX_SCHED_PRIO_EN)
module demux_sched #(
  parameter int NCH     = 16,
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NCH-1:0]     req,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_vld,
  output logic [NCH-1:0]     grant,
  output logic               done,
  output logic [SEL_W-1:0]   done_ch
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic               r_vld, w_vld_nxt;
  logic [NCH-1:0]     r_grant, w_grant_nxt;
  logic               r_done, w_done_nxt;
  logic [SEL_W-1:0]   r_done_ch, w_done_ch_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic [SEL_W-1:0]   r_last, w_last_nxt;

  logic               w_end;
  logic               w_start;
  logic [NCH-1:0]     w_rr_req;
  logic               w_rr_found;
  logic [SEL_W-1:0]   w_rr_pick;
  logic [SEL_W-1:0]   w_pick;
  logic [DWELL_W-1:0] w_dwell_m1;

  // The grant ends on the edge following the cycle in which done was shown
  assign w_end      = (r_state == S_HOLD) && r_done;
  assign w_start    = enable && (|req) && ((r_state == S_IDLE) || r_done);
  assign w_dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  // Round-robin pointer update at grant end; channel-0 grants leave it untouched in priority mode
  always_comb begin
    w_last_nxt = r_last;
`ifdef DEMUX_SCHED_PRIO_EN
    if (w_end && (r_sel != '0)) w_last_nxt = r_sel;
`else
    if (w_end) w_last_nxt = r_sel;
`endif
  end

`ifdef DEMUX_SCHED_PRIO_EN
  assign w_rr_req = req & ~NCH'(1);
`else
  assign w_rr_req = req;
`endif

  // First requester searching upward from last+1 with wrap
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_pick  = '0;
    for (int i = 1; i <= NCH; i++) begin
      if (!w_rr_found && w_rr_req[w_last_nxt + SEL_W'(i)]) begin
        w_rr_found = 1'b1;
        w_rr_pick  = w_last_nxt + SEL_W'(i);
      end
    end
  end

  // Winner selection; channel 0 wins unless its own grant is the one ending
`ifdef DEMUX_SCHED_PRIO_EN
  always_comb begin
    w_pick = '0;
    if (req[0] && !(w_end && (r_sel == '0))) w_pick = '0;
    else if (w_rr_found)                     w_pick = w_rr_pick;
  end
`else
  assign w_pick = w_rr_pick;
`endif

  // Next-state and next-output logic for the IDLE/HOLD FSM
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_vld_nxt     = r_vld;
    w_grant_nxt   = r_grant;
    w_done_nxt    = 1'b0;
    w_done_ch_nxt = r_done_ch;
    w_cnt_nxt     = r_cnt;
    if (w_start) begin
      w_state_nxt = S_HOLD;
      w_sel_nxt   = w_pick;
      w_vld_nxt   = 1'b1;
      w_grant_nxt = NCH'(1) << w_pick;
      w_cnt_nxt   = w_dwell_m1;
      if (w_dwell_m1 == '0) begin
        w_done_nxt    = 1'b1;
        w_done_ch_nxt = w_pick;
      end
    end else if (r_state == S_HOLD) begin
      if (r_done) begin
        w_state_nxt = S_IDLE;
        w_vld_nxt   = 1'b0;
        w_grant_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt - DWELL_W'(1);
        if ((r_cnt == DWELL_W'(1)) || !req[r_sel]) begin
          w_done_nxt    = 1'b1;
          w_done_ch_nxt = r_sel;
        end
      end
    end
  end

  // State and registered outputs; reset aborts any grant without a done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_vld     <= 1'b0;
      r_grant   <= '0;
      r_done    <= 1'b0;
      r_done_ch <= '0;
      r_cnt     <= '0;
      r_last    <= SEL_W'(NCH - 1);
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_vld     <= w_vld_nxt;
      r_grant   <= w_grant_nxt;
      r_done    <= w_done_nxt;
      r_done_ch <= w_done_ch_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
    end
  end

  assign sel     = r_sel;
  assign sel_vld = r_vld;
  assign grant   = r_grant;
  assign done    = r_done;
  assign done_ch = r_done_ch;

endmodule

// File: tb/tb_demux_sched.sv
// tb/tb_demux_sched.sv - scoreboard bench for demux_sched (expectations follow DEMUX_SCHED_PRIO_EN)
module tb_demux_sched;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] req;
  logic [7:0]  dwell;
  logic [3:0]  sel;
  logic        sel_vld;
  logic [15:0] grant;
  logic        done;
  logic [3:0]  done_ch;

  typedef struct {
    int ch;
    int len;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   vld_len = 0;

  demux_sched dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .dwell(dwell),
    .sel(sel), .sel_vld(sel_vld), .grant(grant), .done(done), .done_ch(done_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int ch, input int len);
    exp_t e;
    e.ch  = ch;
    e.len = len;
    q.push_back(e);
  endtask

  // Monitor: per-cycle grant/sel consistency and scoreboard pop on each done pulse
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      vld_len = 0;
    end else begin
      if (sel_vld) begin
        vld_len++;
        check("grant_onehot", int'(grant), int'(16'(1) << sel));
      end else begin
        check("grant_idle", int'(grant), 0);
      end
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done_ch", int'(done_ch), -1);
        end else begin
          e = q.pop_front();
          check("done_ch", int'(done_ch), e.ch);
          check("grant_len", vld_len, e.len);
        end
        vld_len = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (sel_vld && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(sel_vld), 0);
    @(posedge clk); #1;
  endtask

  // Apply a stimulus right after an edge; the next edge starts the first grant
  task automatic run(input logic [15:0] r, input logic [7:0] d, input int edges);
    req = r; dwell = d; enable = 1'b1;
    repeat (edges) @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  initial begin
    int prio_seq[6];
    rst_n = 1'b0; enable = 1'b1; req = 16'hFFFF; dwell = 8'd4;

    // Reset held 3 cycles with all channels requesting
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel_vld", int'(sel_vld), 0);
    check("rst_grant", int'(grant), 0);
    check("rst_done", int'(done), 0);
    check("rst_sel", int'(sel), 0);
    check("rst_done_ch", int'(done_ch), 0);

    // Full rotation 0..15,0 with dwell 4
    for (int i = 0; i < 16; i++) push(i, 4);
    push(0, 4);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_grant_vld", int'(sel_vld), 1);
    check("first_grant_sel", int'(sel), 0);
    repeat (67) @(posedge clk);
    #1;
    enable = 1'b0;
    wait_idle();

    // Sparse requests with wrap, dwell 0 behaves as 1
    push(1, 1); push(15, 1); push(1, 1); push(15, 1);
    run(16'h8002, 8'd0, 4);
    wait_idle();

    // Early release of channel 5
    push(5, 4);
    req = 16'h0020; dwell = 8'd10; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req = 16'h0000;
    wait_idle();
    check("early_sel_hold", int'(sel), 5);
    enable = 1'b0;

    // Enable dropped in the 2nd grant cycle, dwell change ignored
    push(4, 5);
    req = 16'h0010; dwell = 8'd5; enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b0;
    dwell = 8'd1;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("enable_stays_idle", int'(sel_vld), 0);
    req = 16'h0000;

    // Reset mid-grant
    req = 16'h0008; dwell = 8'd8; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_vld", int'(sel_vld), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_vld", int'(sel_vld), 0);
    check("midrst_grant", int'(grant), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_sel", int'(sel), 0);
    req = 16'h0000; enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Priority / round-robin over channels 0..2
`ifdef DEMUX_SCHED_PRIO_EN
    prio_seq = '{0, 1, 0, 2, 0, 1};
`else
    prio_seq = '{0, 1, 2, 0, 1, 2};
`endif
    for (int i = 0; i < 6; i++) push(prio_seq[i], 2);
    run(16'h0007, 8'd2, 12);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
